ex_stage: RTL and testbench

Execute stage of the 16-bit five-stage pipeline, sitting between ID and MEM. Consumes the ID-issued instruction and operands (`ex_ir`, `reg_A`, `reg_B`, `smdr`) and computes `ALUo`. `ALUo` is also the EX-level forwarding source back into ID. Maintains the zero/negative/carry flag register, resolves conditional branches and `JMPR`, and registers results into the EX/MEM pipeline latch.

---
 rtl/ex_stage_pkg.sv | 60 ++++++
 rtl/ex_stage_alu16.sv | 66 ++++++
 rtl/ex_stage.sv | 88 ++++++++
 tb/tb_ex_stage.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared opcode, run-state and opcode-class definitions
// Purpose: opcode encodings (ex_ir[15:11]), the exec run-state value and the
// flag-write opcode classes used by the execute stage and its ALU.
// Ports: none (package).
package ex_stage_pkg;

  typedef enum logic [4:0] {
    OP_NOP   = 5'd0,
    OP_HALT  = 5'd1,
    OP_LOAD  = 5'd2,
    OP_STORE = 5'd3,
    OP_LDIH  = 5'd4,
    OP_ADD   = 5'd5,
    OP_ADDI  = 5'd6,
    OP_ADDC  = 5'd7,
    OP_SUB   = 5'd8,
    OP_SUBI  = 5'd9,
    OP_SUBC  = 5'd10,
    OP_CMP   = 5'd11,
    OP_AND   = 5'd12,
    OP_OR    = 5'd13,
    OP_XOR   = 5'd14,
    OP_SLL   = 5'd15,
    OP_SRL   = 5'd16,
    OP_SLA   = 5'd17,
    OP_SRA   = 5'd18,
    OP_JMPR  = 5'd20,
    OP_BZ    = 5'd21,
    OP_BNZ   = 5'd22,
    OP_BN    = 5'd23,
    OP_BNN   = 5'd24,
    OP_BC    = 5'd25,
    OP_BNC   = 5'd26
  } opcode_t;

  // CPU run state: registers only advance while state == STATE_EXEC.
  localparam logic STATE_EXEC = 1'b1;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 11;

  // Opcodes that write zf/nf (arithmetic, logic, shift, compare).
  function automatic logic writes_zn(input logic [4:0] op);
    case (op)
      OP_LDIH, OP_ADD, OP_ADDI, OP_ADDC, OP_SUB, OP_SUBI, OP_SUBC, OP_CMP,
      OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLA, OP_SRA: writes_zn = 1'b1;
      default: writes_zn = 1'b0;
    endcase
  endfunction

  // Opcodes that write cf (add/subtract family only).
  function automatic logic writes_c(input logic [4:0] op);
    case (op)
      OP_LDIH, OP_ADD, OP_ADDI, OP_ADDC, OP_SUB, OP_SUBI, OP_SUBC, OP_CMP:
        writes_c = 1'b1;
      default: writes_c = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_alu16.sv
// rtl/ex_stage_alu16.sv - combinational 16-bit ALU for the execute stage
// Purpose: computes y (and carry/borrow cout) from opcode op, operands a, b and
// carry-in cin.
// Ports: op[4:0] in, a[15:0] in, b[15:0] in, cin in, y[15:0] out, cout out.
module alu16
  import ex_stage_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] y,
  output logic        cout
);

  logic [16:0] sum;
  logic [16:0] diff;
  logic [16:0] sum_c;
  logic [16:0] diff_c;
  logic [3:0]  sh;
  logic [15:0] shl;

  // Subtraction in 17 bits: bit 16 of the wrapped result is the borrow.
  assign sum    = {1'b0, a} + {1'b0, b};
  assign sum_c  = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
  assign diff   = {1'b0, a} - {1'b0, b};
  assign diff_c = {1'b0, a} - {1'b0, b} - {16'h0000, cin};
  assign sh     = b[3:0];
  assign shl    = a << sh;

  always_comb begin
    y    = 16'h0000;
    cout = 1'b0;
    case (op)
      OP_ADD, OP_ADDI, OP_LDIH, OP_LOAD, OP_STORE, OP_JMPR,
      OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC: begin
        y    = sum[15:0];
        cout = sum[16];
      end
      OP_ADDC: begin
        y    = sum_c[15:0];
        cout = sum_c[16];
      end
      OP_SUB, OP_SUBI, OP_CMP: begin
        y    = diff[15:0];
        cout = diff[16];
      end
      OP_SUBC: begin
        y    = diff_c[15:0];
        cout = diff_c[16];
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SLL: y = shl;
      OP_SRL: y = a >> sh;
      OP_SLA: y = {a[15], shl[14:0]};
      OP_SRA: y = $unsigned($signed(a) >>> sh);
      default: begin
        y    = 16'h0000;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ALU, flag register, branch resolve, EX/MEM latch
// Purpose: computes ALUo for the instruction in EX, keeps zf/nf/cf, resolves
// conditional branches and JMPR, and registers results for MEM.
// Ports: clock, reset (async, active-high), state; ex_ir, reg_A, reg_B, smdr in;
// ALUo, mem_ir, reg_C, smdr1, dw, zf, nf, cf, branch_taken, branch_addr out.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        state,
  input  logic [15:0] ex_ir,
  input  logic [15:0] reg_A,
  input  logic [15:0] reg_B,
  input  logic [15:0] smdr,
  output logic [15:0] ALUo,
  output logic [15:0] mem_ir,
  output logic [15:0] reg_C,
  output logic [15:0] smdr1,
  output logic        dw,
  output logic        zf,
  output logic        nf,
  output logic        cf,
  output logic        branch_taken,
  output logic [15:0] branch_addr
);

  logic [4:0] op;
  logic       alu_cout;
  logic       take;
  logic       run;

  assign op  = ex_ir[OP_MSB:OP_LSB];
  assign run = (state == STATE_EXEC);

  alu16 u_alu (
    .op   (op),
    .a    (reg_A),
    .b    (reg_B),
    .cin  (cf),
    .y    (ALUo),
    .cout (alu_cout)
  );

  // Branches test the flags left by the previous EX instruction; the flags of
  // the instruction now in EX are not written until the coming edge.
  always_comb begin
    take = 1'b0;
    case (op)
      OP_BZ:   take = zf;
      OP_BNZ:  take = ~zf;
      OP_BN:   take = nf;
      OP_BNN:  take = ~nf;
      OP_BC:   take = cf;
      OP_BNC:  take = ~cf;
      OP_JMPR: take = 1'b1;
      default: take = 1'b0;
    endcase
  end

  assign branch_taken = run & take;
  assign branch_addr  = ALUo;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_ir <= 16'h0000;
      reg_C  <= 16'h0000;
      smdr1  <= 16'h0000;
      dw     <= 1'b0;
      zf     <= 1'b0;
      nf     <= 1'b0;
      cf     <= 1'b0;
    end else if (run) begin
      mem_ir <= ex_ir;
      reg_C  <= ALUo;
      smdr1  <= smdr;
      dw     <= (op == OP_STORE);
      if (writes_zn(op)) begin
        zf <= (ALUo == 16'h0000);
        nf <= ALUo[15];
      end
      if (writes_c(op)) begin
        cf <= alu_cout;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed self-checking bench for ex_stage
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        state = 1'b0;
  logic [15:0] ex_ir = 16'h0000;
  logic [15:0] reg_A = 16'h0000;
  logic [15:0] reg_B = 16'h0000;
  logic [15:0] smdr  = 16'h0000;
  logic [15:0] ALUo, mem_ir, reg_C, smdr1, branch_addr;
  logic        dw, zf, nf, cf, branch_taken;

  int checks = 0;
  int errors = 0;

  ex_stage dut (
    .clock        (clock),
    .reset        (reset),
    .state        (state),
    .ex_ir        (ex_ir),
    .reg_A        (reg_A),
    .reg_B        (reg_B),
    .smdr         (smdr),
    .ALUo         (ALUo),
    .mem_ir       (mem_ir),
    .reg_C        (reg_C),
    .smdr1        (smdr1),
    .dw           (dw),
    .zf           (zf),
    .nf           (nf),
    .cf           (cf),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] rd);
    mk = {op, rd, 8'h00};
  endfunction

  // Drive a new instruction just after a falling edge, settle 1 time unit.
  task automatic drive(input logic [4:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] sd);
    @(negedge clock);
    ex_ir = mk(op, 3'd1);
    reg_A = a;
    reg_B = b;
    smdr  = sd;
    #1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    state = 1'b0;
    ex_ir = 16'h0000;
    reset = 1'b1;
    #3;
    checks++;
    if ({mem_ir, reg_C, smdr1} !== 48'h0 || {dw, zf, nf, cf} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_regs mem_ir=%h reg_C=%h smdr1=%h dw/zf/nf/cf=%b%b%b%b want all 0",
               mem_ir, reg_C, smdr1, dw, zf, nf, cf);
    end
    checks++;
    if (ALUo !== 16'h0000 || branch_taken !== 1'b0) begin
      errors++;
      $display("FAIL reset_comb ALUo=%h bt=%b want 0000/0", ALUo, branch_taken);
    end
    @(negedge clock);
    reset = 1'b0;
    state = STATE_EXEC;
  endtask

  task automatic test_add();
    drive(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000);
    checks++;
    if (ALUo !== 16'h0000) begin
      errors++;
      $display("FAIL add_aluo got %h want 0000", ALUo);
    end
    step();
    checks++;
    if (reg_C !== 16'h0000 || {zf, nf, cf} !== 3'b101 || mem_ir !== mk(OP_ADD, 3'd1)) begin
      errors++;
      $display("FAIL add_latch reg_C=%h zf/nf/cf=%b%b%b mem_ir=%h want 0000 101 %h",
               reg_C, zf, nf, cf, mem_ir, mk(OP_ADD, 3'd1));
    end
  endtask

  task automatic test_sub_bc();
    drive(OP_SUB, 16'h0003, 16'h0005, 16'h0000);
    checks++;
    if (ALUo !== 16'hFFFE) begin
      errors++;
      $display("FAIL sub_aluo got %h want fffe", ALUo);
    end
    step();
    checks++;
    if (reg_C !== 16'hFFFE || {zf, nf, cf} !== 3'b011) begin
      errors++;
      $display("FAIL sub_flags reg_C=%h zf/nf/cf=%b%b%b want fffe 011", reg_C, zf, nf, cf);
    end
    drive(OP_BC, 16'h0100, 16'h0004, 16'h0000);
    checks++;
    if (branch_taken !== 1'b1 || branch_addr !== 16'h0104) begin
      errors++;
      $display("FAIL bc_taken bt=%b addr=%h want 1 0104", branch_taken, branch_addr);
    end
    drive(OP_BNC, 16'h0100, 16'h0004, 16'h0000);
    checks++;
    if (branch_taken !== 1'b0) begin
      errors++;
      $display("FAIL bnc_not_taken bt=%b want 0", branch_taken);
    end
    step();
    checks++;
    if ({zf, nf, cf} !== 3'b011 || mem_ir !== mk(OP_BNC, 3'd1)) begin
      errors++;
      $display("FAIL branch_holds_flags zf/nf/cf=%b%b%b mem_ir=%h want 011 %h",
               zf, nf, cf, mem_ir, mk(OP_BNC, 3'd1));
    end
  endtask

  task automatic test_carry_chain();
    // cf=1 from the SUB borrow: 1+2+1 = 4, no carry out
    drive(OP_ADDC, 16'h0001, 16'h0002, 16'h0000);
    checks++;
    if (ALUo !== 16'h0004) begin
      errors++;
      $display("FAIL addc_aluo got %h want 0004", ALUo);
    end
    step();
    checks++;
    if (cf !== 1'b0 || zf !== 1'b0) begin
      errors++;
      $display("FAIL addc_flags cf=%b zf=%b want 0 0", cf, zf);
    end
    // cf=0 now: 5-5-0 = 0, no borrow; BZ behind it sees zf=1 with no stall
    drive(OP_SUBC, 16'h0005, 16'h0005, 16'h0000);
    checks++;
    if (ALUo !== 16'h0000) begin
      errors++;
      $display("FAIL subc_aluo got %h want 0000", ALUo);
    end
    step();
    drive(OP_BZ, 16'h0040, 16'h0002, 16'h0000);
    checks++;
    if ({zf, nf, cf} !== 3'b100 || branch_taken !== 1'b1 || branch_addr !== 16'h0042) begin
      errors++;
      $display("FAIL subc_bz zf/nf/cf=%b%b%b bt=%b addr=%h want 100 1 0042",
               zf, nf, cf, branch_taken, branch_addr);
    end
    step();
  endtask

  task automatic test_shift();
    drive(OP_SRA, 16'h8000, 16'h0004, 16'h0000);
    checks++;
    if (ALUo !== 16'hF800) begin
      errors++;
      $display("FAIL sra got %h want f800", ALUo);
    end
    drive(OP_SRL, 16'h8000, 16'h0004, 16'h0000);
    checks++;
    if (ALUo !== 16'h0800) begin
      errors++;
      $display("FAIL srl got %h want 0800", ALUo);
    end
    drive(OP_SLA, 16'h8001, 16'h0014, 16'h0000);
    checks++;
    if (ALUo !== 16'h8010) begin
      errors++;
      $display("FAIL sla got %h want 8010", ALUo);
    end
    drive(OP_SLL, 16'h8001, 16'h0014, 16'h0000);
    checks++;
    if (ALUo !== 16'h0010) begin
      errors++;
      $display("FAIL sll got %h want 0010", ALUo);
    end
    step();
    // SLL result 0010 -> zf=0 nf=0, cf untouched (0)
    checks++;
    if ({zf, nf, cf} !== 3'b000) begin
      errors++;
      $display("FAIL sll_flags zf/nf/cf=%b%b%b want 000", zf, nf, cf);
    end
  endtask

  task automatic test_store();
    drive(OP_SUB, 16'h0000, 16'h0001, 16'h0000);
    step();
    // flags now zf=0 nf=1 cf=1; STORE must leave them alone
    drive(OP_STORE, 16'h0010, 16'h0003, 16'hBEEF);
    step();
    checks++;
    if (reg_C !== 16'h0013 || smdr1 !== 16'hBEEF || dw !== 1'b1) begin
      errors++;
      $display("FAIL store_latch reg_C=%h smdr1=%h dw=%b want 0013 beef 1",
               reg_C, smdr1, dw);
    end
    checks++;
    if ({zf, nf, cf} !== 3'b011) begin
      errors++;
      $display("FAIL store_flags zf/nf/cf=%b%b%b want 011", zf, nf, cf);
    end
  endtask

  task automatic test_stall();
    @(negedge clock);
    state = 1'b0;
    ex_ir = mk(OP_JMPR, 3'd0);
    reg_A = 16'h0020;
    reg_B = 16'h0002;
    smdr  = 16'h1234;
    #1;
    checks++;
    if (branch_taken !== 1'b0 || ALUo !== 16'h0022) begin
      errors++;
      $display("FAIL stall_bt bt=%b ALUo=%h want 0 0022", branch_taken, ALUo);
    end
    step();
    checks++;
    if (mem_ir !== mk(OP_STORE, 3'd1) || reg_C !== 16'h0013 || smdr1 !== 16'hBEEF ||
        dw !== 1'b1 || {zf, nf, cf} !== 3'b011) begin
      errors++;
      $display("FAIL stall_hold mem_ir=%h reg_C=%h smdr1=%h dw=%b flags=%b%b%b want %h 0013 beef 1 011",
               mem_ir, reg_C, smdr1, dw, zf, nf, cf, mk(OP_STORE, 3'd1));
    end
    @(negedge clock);
    state = STATE_EXEC;
    #1;
    checks++;
    if (branch_taken !== 1'b1 || branch_addr !== 16'h0022) begin
      errors++;
      $display("FAIL resume_bt bt=%b addr=%h want 1 0022", branch_taken, branch_addr);
    end
    step();
    checks++;
    if (mem_ir !== mk(OP_JMPR, 3'd0) || reg_C !== 16'h0022 || dw !== 1'b0) begin
      errors++;
      $display("FAIL jmpr_latch mem_ir=%h reg_C=%h dw=%b want %h 0022 0",
               mem_ir, reg_C, dw, mk(OP_JMPR, 3'd0));
    end
  endtask

  task automatic test_async_reset();
    drive(OP_ADD, 16'h7FFF, 16'h8000, 16'h5555);
    step();
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_ir, reg_C, smdr1} !== 48'h0 || {dw, zf, nf, cf} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset mem_ir=%h reg_C=%h smdr1=%h dw/zf/nf/cf=%b%b%b%b want all 0",
               mem_ir, reg_C, smdr1, dw, zf, nf, cf);
    end
    // reset still high across an exec edge must keep everything cleared
    step();
    checks++;
    if (reg_C !== 16'h0000 || mem_ir !== 16'h0000 || zf !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_edge reg_C=%h mem_ir=%h zf=%b want 0000 0000 0",
               reg_C, mem_ir, zf);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_bc();
    test_carry_chain();
    test_shift();
    test_store();
    test_stall();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
